// File: rtl/data_memory_block_pkg.sv
// Memory-interface definitions shared by the data memory and the cache controller.
package data_memory_block_pkg;

    localparam int MEM_ADDR_WIDTH = 6;
    localparam int BLOCK_WIDTH    = 32;
    localparam int DEPTH          = 64;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_DONE   = 2'b10
    } mem_state_e;

endpackage

// File: rtl/data_memory_array.sv
// Block storage: synchronous write, synchronous read into an output register,
// asynchronous active-low clear of every block and of the read register.
module data_memory_array #(
    parameter int DEPTH       = 64,
    parameter int BLOCK_WIDTH = 32,
    parameter int ADDR_WIDTH  = 6
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   wr_en_i,
    input  logic                   rd_en_i,
    input  logic [ADDR_WIDTH-1:0]  addr_i,
    input  logic [BLOCK_WIDTH-1:0] wdata_i,
    output logic [BLOCK_WIDTH-1:0] rdata_o
);

    logic [BLOCK_WIDTH-1:0] mem_q [DEPTH];
    logic [BLOCK_WIDTH-1:0] rdata_q;

    // Storage and read register; a read leaves storage untouched and a write
    // leaves the read register holding its last result.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rdata_q <= '0;
        end else begin
            if (wr_en_i) begin
                mem_q[addr_i] <= wdata_i;
            end
            if (rd_en_i) begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_memory_block.sv
// Block-organised data memory answering the cache controller. One whole-block
// access at a time, committed after ACCESS_CYCLES edges in ACCESS.
//
//   state     | meaning
//   ST_IDLE   | waiting; exactly one enable starts an access
//   ST_ACCESS | request latched, counting down to the commit edge
//   ST_DONE   | one-cycle handshake, busywait low, enables ignored
module data_memory_block #(
    parameter int ACCESS_CYCLES = 5,
    parameter int DEPTH         = data_memory_block_pkg::DEPTH,
    parameter int BLOCK_WIDTH   = data_memory_block_pkg::BLOCK_WIDTH
) (
    input  logic                                          CLK,
    input  logic                                          RESET,
    input  logic                                          READENABLE_MEM,
    input  logic                                          WRITEENABLE_MEM,
    input  logic [data_memory_block_pkg::MEM_ADDR_WIDTH-1:0] MEM_ADDRESS,
    input  logic [BLOCK_WIDTH-1:0]                        MEM_WRITEDATA,
    output logic [BLOCK_WIDTH-1:0]                        MEM_READDATA,
    output logic                                          MEM_BUSYWAIT
);

    import data_memory_block_pkg::*;

    localparam int AW    = MEM_ADDR_WIDTH;
    localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYCLES - 1);

    mem_state_e             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   op_write_q, op_write_d;
    logic [AW-1:0]          addr_q, addr_d;
    logic [BLOCK_WIDTH-1:0] data_q, data_d;

    logic request;
    logic commit;

    // Both enables together is an illegal request and is simply not seen.
    assign request = READENABLE_MEM ^ WRITEENABLE_MEM;
    assign commit  = (state_q == ST_ACCESS) && (cnt_q == '0);

    // State, countdown and the latched request.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            op_write_q <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_write_q <= op_write_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
        end
    end

    // Next-state: accept in IDLE, count down in ACCESS, single DONE cycle.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_write_d = op_write_q;
        addr_d     = addr_q;
        data_d     = data_q;
        case (state_q)
            ST_IDLE: begin
                if (request) begin
                    op_write_d = WRITEENABLE_MEM;
                    addr_d     = MEM_ADDRESS;
                    data_d     = MEM_WRITEDATA;
                    cnt_d      = CNT_LOAD;
                    state_d    = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Gated by RESET so a requester holding an enable during reset sees no busy.
    always_comb begin
        MEM_BUSYWAIT = RESET && (((state_q == ST_IDLE) && request) || (state_q == ST_ACCESS));
    end

    data_memory_array #(
        .DEPTH      (DEPTH),
        .BLOCK_WIDTH(BLOCK_WIDTH),
        .ADDR_WIDTH (AW)
    ) u_array (
        .clk_i  (CLK),
        .rst_ni (RESET),
        .wr_en_i(commit && op_write_q),
        .rd_en_i(commit && !op_write_q),
        .addr_i (addr_q),
        .wdata_i(data_q),
        .rdata_o(MEM_READDATA)
    );

endmodule

// File: tb/tb_data_memory_block.sv
// Bench for data_memory_block: a 5-cycle instance checked against an array
// model of the memory, plus a 1-cycle instance for back-to-back handshakes.
module tb_data_memory_block;

    localparam int ACC = 5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        re, we;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        busy;

    logic        re1, we1;
    logic [5:0]  addr1;
    logic [31:0] wdata1;
    logic [31:0] rdata1;
    logic        busy1;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] model_mem [64];
    logic [31:0] model_rd;

    always #5 clk = ~clk;

    data_memory_block #(.ACCESS_CYCLES(ACC)) dut (
        .CLK            (clk),
        .RESET          (rst_n),
        .READENABLE_MEM (re),
        .WRITEENABLE_MEM(we),
        .MEM_ADDRESS    (addr),
        .MEM_WRITEDATA  (wdata),
        .MEM_READDATA   (rdata),
        .MEM_BUSYWAIT   (busy)
    );

    data_memory_block #(.ACCESS_CYCLES(1)) dut1 (
        .CLK            (clk),
        .RESET          (rst_n),
        .READENABLE_MEM (re1),
        .WRITEENABLE_MEM(we1),
        .MEM_ADDRESS    (addr1),
        .MEM_WRITEDATA  (wdata1),
        .MEM_READDATA   (rdata1),
        .MEM_BUSYWAIT   (busy1)
    );

    task automatic model_clear();
        for (int i = 0; i < 64; i++) model_mem[i] = 32'h0;
        model_rd = 32'h0;
    endtask

    // One complete access on the 5-cycle instance. mode 0: inputs held,
    // 1: specific overwrite after acceptance, 2: random scribbling each cycle.
    task automatic dut_access(input bit wr, input logic [5:0] a, input logic [31:0] d,
                              input int mode);
        @(negedge clk);
        re = !wr; we = wr; addr = a; wdata = d;
        #1;
        n_checks++;
        if (busy !== 1'b1) $display("FAIL busy_on_request addr=%h: got %b want 1", a, busy);
        else n_pass++;
        @(posedge clk);
        for (int k = 1; k <= ACC; k++) begin
            @(negedge clk);
            n_checks++;
            if (busy !== 1'b1) $display("FAIL busy_in_access k=%0d: got %b want 1", k, busy);
            else n_pass++;
            n_checks++;
            if (rdata !== model_rd) $display("FAIL rdata_hold k=%0d: got %h want %h", k, rdata, model_rd);
            else n_pass++;
            if (mode == 1 && k == 1) begin
                addr = 6'h3F; wdata = 32'h0;
            end else if (mode == 2) begin
                addr = 6'($urandom); wdata = $urandom;
            end
            @(posedge clk);
        end
        if (wr) model_mem[a] = d;
        else model_rd = model_mem[a];
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) $display("FAIL busy_in_done addr=%h: got %b want 0", a, busy);
        else n_pass++;
        n_checks++;
        if (rdata !== model_rd) $display("FAIL rdata_after_commit addr=%h: got %h want %h", a, rdata, model_rd);
        else n_pass++;
        re = 1'b0; we = 1'b0;
        @(posedge clk);
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if (rdata !== 32'h0) $display("FAIL reset_rdata: got %h want 0", rdata);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy);
        else n_pass++;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        dut_access(1'b0, 6'h2A, 32'h0, 0);
    endtask

    task automatic test_write_read();
        dut_access(1'b1, 6'h15, 32'hDEADBEEF, 0);
        dut_access(1'b0, 6'h15, 32'h0, 0);
    endtask

    task automatic test_stability();
        dut_access(1'b1, 6'h3F, 32'h5A5A0F0F, 0);
        dut_access(1'b1, 6'h15, 32'hCAFEF00D, 1);
        dut_access(1'b0, 6'h15, 32'h0, 0);
        dut_access(1'b0, 6'h3F, 32'h0, 0);
    endtask

    task automatic test_illegal();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            re = 1'b1; we = 1'b1; addr = 6'h15; wdata = 32'h11111111;
            #1;
            n_checks++;
            if (busy !== 1'b0) $display("FAIL illegal_busy k=%0d: got %b want 0", k, busy);
            else n_pass++;
        end
        @(negedge clk);
        re = 1'b0; we = 1'b0;
        dut_access(1'b0, 6'h15, 32'h0, 0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 24; n++) begin
            dut_access(1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), $urandom, 2);
        end
        for (int n = 0; n < 6; n++) begin
            dut_access(1'b0, 6'($urandom_range(0, 63)), 32'h0, 0);
        end
    endtask

    task automatic test_reset_mid_clock();
        dut_access(1'b0, 6'h15, 32'h0, 0);
        @(posedge clk);
        #3;
        re = 1'b1; addr = 6'h15;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (rdata !== 32'h0) $display("FAIL async_reset_rdata: got %h want 0", rdata);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL async_reset_busy: got %b want 0", busy);
        else n_pass++;
        re = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        dut_access(1'b0, 6'h15, 32'h0, 0);
        dut_access(1'b0, 6'h2A, 32'h0, 0);
    endtask

    task automatic test_reset_mid_write();
        dut_access(1'b1, 6'h01, 32'hAAAA5555, 0);
        dut_access(1'b0, 6'h01, 32'h0, 0);
        @(negedge clk);
        we = 1'b1; addr = 6'h01; wdata = 32'h12345678;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL midwrite_reset_busy: got %b want 0", busy);
        else n_pass++;
        n_checks++;
        if (rdata !== 32'h0) $display("FAIL midwrite_reset_rdata: got %h want 0", rdata);
        else n_pass++;
        we = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        #1;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL midwrite_idle_busy: got %b want 0", busy);
        else n_pass++;
        dut_access(1'b0, 6'h01, 32'h0, 0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] v_old, v_new;
        v_old = $urandom | 32'h1;
        v_new = ~v_old;
        // Seed address 0 on the 1-cycle instance.
        @(negedge clk);
        we1 = 1'b1; addr1 = 6'h00; wdata1 = v_old;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        we1 = 1'b0;
        @(posedge clk);
        // Read immediately followed by write.
        @(negedge clk);
        re1 = 1'b1; addr1 = 6'h00;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (busy1 !== 1'b1) $display("FAIL b2b_read_busy: got %b want 1", busy1);
        else n_pass++;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (rdata1 !== v_old) $display("FAIL b2b_read_data: got %h want %h", rdata1, v_old);
        else n_pass++;
        re1 = 1'b0; we1 = 1'b1; wdata1 = v_new;
        #1;
        n_checks++;
        if (busy1 !== 1'b0) $display("FAIL b2b_done_busy: got %b want 0", busy1);
        else n_pass++;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (busy1 !== 1'b1) $display("FAIL b2b_write_request_busy: got %b want 1", busy1);
        else n_pass++;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (busy1 !== 1'b1) $display("FAIL b2b_write_access_busy: got %b want 1", busy1);
        else n_pass++;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (busy1 !== 1'b0) $display("FAIL b2b_write_done_busy: got %b want 0", busy1);
        else n_pass++;
        n_checks++;
        if (rdata1 !== v_old) $display("FAIL b2b_write_keeps_rdata: got %h want %h", rdata1, v_old);
        else n_pass++;
        we1 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        re1 = 1'b1; addr1 = 6'h00;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (rdata1 !== v_new) $display("FAIL b2b_readback: got %h want %h", rdata1, v_new);
        else n_pass++;
        re1 = 1'b0;
        @(posedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        re = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        re1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
        model_clear();
        test_reset();
        test_write_read();
        test_stability();
        test_illegal();
        test_random();
        test_reset_mid_clock();
        test_reset_mid_write();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
